imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer for instruction_mem: owns the PC, issues word reads (rd/instr_addr) and
//  buffers returned words with their PC in a small FIFO for decode (valid/ready).
//  Handles branch/jump redirects, including killing a read already in flight.
//  Sits between instruction_mem and the decode stage of the RV32 core.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first fetch after reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              fetch-buffer entries (>=2); 2 gives 1 instr/cycle
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, asynchronous, active-high
//  imem_rd         out  1   read strobe to instruction_mem (rd)
//  imem_addr       out  32  byte address to instruction_mem (instr_addr), word aligned
//  imem_instr      in   32  instruction_mem data (instr), valid the cycle after imem_rd
//  redirect_valid  in   1   redirect request from execute (one-cycle pulse)
//  redirect_pc     in   32  redirect target
//  if_valid        out  1   if_pc/if_instr hold a valid fetched instruction
//  if_ready        in   1   decode accepts; transfer when if_valid && if_ready
//  if_pc           out  32  PC of if_instr
//  if_instr        out  32  fetched instruction word
//  fetch_err       out  1   sticky: misaligned redirect target, fetch halted
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, FIFO empty, inflight=0, kill=0, state=S_BOOT,
//    fetch_err=0; outputs imem_rd=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
//  - FSM: S_BOOT -> S_RUN after 1 cycle (no issue in S_BOOT).
//    S_RUN -> S_HALT on redirect with redirect_pc[1:0]!=0 (fetch_err<=1).
//    S_HALT -> S_RUN on redirect with aligned target (fetch_err<=0, pc<=target).
//  - imem_addr = pc (combinational). pop = if_valid && if_ready.
//  - issue = (state==S_RUN) && !redirect_valid && (count + inflight - pop < FIFO_DEPTH).
//    imem_rd = issue; on issue pc <= pc+4 (mod 2^32: 32'hFFFF_FFFC wraps to 0), inflight<=1.
//  - Response: cycle after issue, {pc_issued, imem_instr} pushed unless kill set;
//    inflight cleared. Read latency 1; fetch-to-if_valid latency 2 cycles minimum.
//  - if_valid = !empty && !redirect_valid; if_pc/if_instr = FIFO head (0 when empty).
//  - Redirect (any state): FIFO flushed; no pop and no issue that cycle; if a read is in
//    flight, kill<=1 and its response is discarded next cycle; pc<=redirect_pc if aligned.
//    First fetch from the target is issued the cycle after the redirect.
//  - Push and pop in same cycle: count unchanged; push never occurs when full (guaranteed
//    by issue rule); pop when empty impossible (if_valid=0).
//  - Redirect in the same cycle as a response: response dropped, flush wins.
//  - Reset mid-operation: all state cleared immediately; in-flight data ignored.
//  - Backpressure: if_ready=0 holds head stable; issue stops once count+inflight=DEPTH.
// STRUCTURE
//  - fetch_defs.vh (shared include): XLEN=32, INSTR_NOP=32'h0000_0013, PC_STEP=4,
//    FSM encodings S_BOOT=2'd0, S_RUN=2'd1, S_HALT=2'd2.
//  - Sub-module fetch_fifo: FIFO_DEPTH x 64-bit {pc,instr}, push/pop/flush, count, empty/full,
//    async reset. Top holds FSM, pc, inflight/kill bits, issue logic.
// TESTING (imem loaded with word i = 32'h0000_0013 + (i<<7), instr_addr byte address)
//  1 Reset: rst=1 for 3 cycles then 0 -> imem_rd=0 in S_BOOT; first imem_rd next cycle
//    with imem_addr=0; if_valid rises 2 cycles later with if_pc=0, if_instr=32'h13.
//  2 Stream, if_ready=1 always -> one transfer per cycle, if_pc 0,4,8,...,0x3C in order,
//    no gaps after the first.
//  3 Backpressure: if_ready=0 for 5 cycles mid-stream -> head frozen, imem_rd low once
//    count=2, no instruction lost or duplicated after if_ready=1.
//  4 Redirect to 0x40 while a read of 0x10 in flight -> 0x10 never appears; next if_pc=0x40;
//    if_valid=0 in the redirect cycle.
//  5 Redirect to 0x42 -> fetch_err=1, imem_rd=0 thereafter; redirect to 0x80 ->
//    fetch_err=0, next if_pc=0x80.
//  6 Assert rst asynchronously mid-stream (between edges) -> if_valid, imem_rd fall at
//    once; fetch restarts from RESET_PC per scenario 1.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: datapath widths,
// PC stride, FSM encodings and the {pc, instr} fetch-buffer entry.
package imem_fetch_ctrl_pkg;

    localparam int          XLEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    // FSM encodings kept as plain constants so older netlists and probes still match.
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // One fetch-buffer entry: the instruction word together with the PC it was read from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // A fetch target is legal only when it names a whole 32-bit word.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Fetch buffer: DEPTH entries of {pc, instr} with push, pop and flush.
// The head reads as zero when the buffer is empty.
module imem_fetch_ctrl_fifo
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage; an entry is only observable while count covers it.
    // NOTE: storage has no reset -- count/empty gate every read, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush discards everything in one cycle.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer between instruction_mem and decode: owns the PC, issues
// one-cycle-latency word reads, buffers returned words with their PC and
// handles redirects, including discarding a read that is already in flight.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]     state;
    logic [31:0]    pc;
    logic [31:0]    issued_pc;
    logic           inflight;
    logic           kill;

    logic           issue;
    logic           pop;
    logic           fifo_push;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    occupancy;
    logic [CW:0]    capacity;
    logic           redirect_ok;
    fetch_entry_t   fifo_head;
    fetch_entry_t   resp_entry;

    assign redirect_ok = is_word_aligned(redirect_pc);
    assign pop         = if_valid && if_ready;

    // Issue only when the word, once returned, is certain to find a free slot.
    // NOTE: every signal driven here gets a value first, so no latch can be inferred.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
        capacity  = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
        issue     = (state == S_RUN) && !redirect_valid && (occupancy < capacity);
    end

    // A returning word is kept unless a redirect killed it or is flushing right now.
    assign fifo_push  = inflight && !kill && !redirect_valid;
    assign resp_entry = '{pc: issued_pc, instr: imem_instr};

    // Boot / run / halt sequencing and the sticky misaligned-target error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_BOOT;
            fetch_err <= 1'b0;
        end else if (redirect_valid) begin
            state     <= redirect_ok ? S_RUN : S_HALT;
            fetch_err <= !redirect_ok;
        end else if (state == S_BOOT) begin
            state     <= S_RUN;
        end
    end

    // PC advance, issued-address capture and in-flight / kill bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            kill      <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= redirect_valid && inflight;
            if (issue) begin
                issued_pc <= pc;
                pc        <= pc + PC_STEP;
            end
            if (redirect_valid && redirect_ok) begin
                pc <= redirect_pc;
            end
        end
    end

    imem_fetch_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign imem_rd   = issue;
    assign imem_addr = pc;
    assign if_valid  = !fifo_empty && !redirect_valid;
    assign if_pc     = fifo_head.pc;
    assign if_instr  = fifo_head.instr;

    // The issue rule must never let a word arrive at a buffer with no room for it.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !pop));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a one-cycle-latency instruction memory model,
// a scoreboard of expected transfer PCs and a monitor that checks every
// decode handshake against it, plus directed cycle-level checks.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_pc;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word i holds 0x13 + (i << 7).
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_0013 + ((addr >> 2) << 7);
    endfunction

    always @(posedge clk) begin
        if (imem_rd) imem_instr <= mem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted instruction must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (!rst && if_valid && if_ready) begin
            mon_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("xfer_pc", if_pc, mon_pc);
            check("xfer_instr", if_instr, mem_word(mon_pc));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with rst high; releases reset (cycle 0 = boot) and
    // checks the start-up timeline, returning in cycle 3.
    task automatic boot_sequence();
        rst = 1'b0;
        #2;
        check("boot_no_rd", imem_rd, 1'b0);
        next_cycle(); #2;
        check("first_rd", imem_rd, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        next_cycle(); #2;
        check("valid_lat_lo", if_valid, 1'b0);
        next_cycle(); #2;
        check("valid_lat_hi", if_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_instr     = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_rd", imem_rd, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_fetch_err", fetch_err, 1'b0);

        // Stream 0x00..0x3C with a 5-cycle decode stall in the middle.
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        boot_sequence();
        for (int c = 4; c <= 23; c++) begin
            next_cycle();
            if_ready = !(c >= 8 && c <= 12);
            #2;
            if (c >= 8 && c <= 12) begin
                check("bp_no_issue", imem_rd, 1'b0);
                check("bp_head_pc", if_pc, 32'h14);
                check("bp_head_instr", if_instr, mem_word(32'h14));
            end
        end

        // Asynchronous reset between edges while the stream is still running.
        next_cycle();
        check("pre_rst_valid", if_valid, 1'b1);
        check("pre_rst_rd", imem_rd, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", if_valid, 1'b0);
        check("async_rst_rd", imem_rd, 1'b0);
        check("stream_drained", exp_q.size(), 0);
        next_cycle();
        next_cycle();

        // Restart, redirect while 0x10 returns, then a misaligned and an aligned redirect.
        exp_q.push_back(32'h00);
        exp_q.push_back(32'h04);
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h84);
        exp_q.push_back(32'h88);
        boot_sequence();
        for (int c = 4; c <= 24; c++) begin
            next_cycle();
            redirect_valid = (c == 6) || (c == 11) || (c == 16);
            redirect_pc    = (c == 6) ? 32'h40 : (c == 11) ? 32'h42 : 32'h80;
            if_ready       = (c < 22);
            #2;
            if (c == 6) begin
                check("redir_valid_lo", if_valid, 1'b0);
                check("redir_no_issue", imem_rd, 1'b0);
            end
            if (c == 7) begin
                check("redir_first_rd", imem_rd, 1'b1);
                check("redir_first_addr", imem_addr, 32'h40);
            end
            if (c == 11) check("misalign_valid_lo", if_valid, 1'b0);
            if (c >= 12 && c <= 15) begin
                check("halt_err", fetch_err, 1'b1);
                check("halt_no_rd", imem_rd, 1'b0);
                check("halt_no_valid", if_valid, 1'b0);
            end
            if (c == 17) begin
                check("resume_err_clr", fetch_err, 1'b0);
                check("resume_rd", imem_rd, 1'b1);
                check("resume_addr", imem_addr, 32'h80);
            end
        end
        check("redirect_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
